stopwatch_mux: RTL and testbench

Parametrised multi-digit BCD stopwatch with lap memory, lap recall and a time-multiplexed seven-segment driver. It is the next-generation core of the stopwatch project, sitting between the board button inputs (`ui_in`) and the seven-segment Pmod (`uo_out`/`uio_out`). Compared with the 2-digit design, it adds:

- a configurable digit count;
- a multi-entry lap buffer with recall;
- button synchronisation and edge detection;
- a sticky overflow flag;
- one-hot digit scanning instead of a fixed two-digit toggle.

---
 rtl/stopwatch_mux.sv | 219 +++++++++++++++++++++
 tb/tb_stopwatch_mux.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mux.sv
// Multi-digit BCD stopwatch with a lap buffer and lap recall. It drives a one-hot
// multiplexed seven-segment display, and all button inputs are synchronised on-chip.
module stopwatch_mux #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 120000,
    parameter int unsigned SCAN_DIV   = 1024,
    parameter int unsigned LAP_DEPTH  = 4,
    parameter int unsigned LAP_HOLD   = 20
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           btn_clear,
    input  logic                           btn_start,
    input  logic                           btn_stop,
    input  logic                           btn_lap,
    input  logic                           btn_recall,
    output logic [7:0]                     seg_n,
    output logic [NUM_DIGITS-1:0]          dig_sel,
    output logic                           running,
    output logic                           overflow,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count
);

    localparam int unsigned CW  = 4 * NUM_DIGITS;
    localparam int unsigned LCW = $clog2(LAP_DEPTH + 1);
    localparam int unsigned DW  = $clog2(TICK_DIV);
    localparam int unsigned SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW  = $clog2(NUM_DIGITS);
    localparam int unsigned LIW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int unsigned HW  = (LAP_HOLD > 0) ? $clog2(LAP_HOLD + 1) : 1;

    typedef enum logic [0:0] {StLive, StShowLap} mode_e;

    logic [4:0]      btn_raw, sync1_q, sync2_q, sync3_q, press_q;
    logic            do_clear, do_stop, do_start, do_lap, do_recall;
    logic [DW-1:0]   div_q;
    logic            tick_edge;
    logic [CW-1:0]   count_q, count_inc;
    logic            wrap;
    logic            running_q, overflow_q;
    logic [CW-1:0]   laps_q [LAP_DEPTH];
    logic [LCW-1:0]  lap_count_q;
    mode_e           mode_q, mode_d;
    logic [LIW-1:0]  idx_q, idx_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [IW-1:0]   scan_idx_q;
    logic [SW-1:0]   scan_cnt_q;
    logic [CW-1:0]   disp;
    logic [3:0]      cur_digit;
    logic [7:0]      seg_q;
    logic [NUM_DIGITS-1:0] dig_q;

    // Bit order doubles as priority order: bit 0 (clear) wins.
    assign btn_raw   = {btn_recall, btn_lap, btn_start, btn_stop, btn_clear};
    assign do_clear  = press_q[0];
    assign do_stop   = press_q[1] && (press_q[0] == 1'b0);
    assign do_start  = press_q[2] && (press_q[1:0] == 2'b00);
    assign do_lap    = press_q[3] && (press_q[2:0] == 3'b000);
    assign do_recall = press_q[4] && (press_q[3:0] == 4'b0000);

    assign tick_edge = (div_q == DW'(TICK_DIV - 1));

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Ripple BCD increment; wrap flags the all-9s case.
    always_comb begin
        logic carry;
        count_inc = count_q;
        carry     = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            press_q     <= '0;
            div_q       <= '0;
            count_q     <= '0;
            running_q   <= 1'b0;
            overflow_q  <= 1'b0;
            lap_count_q <= '0;
            for (int k = 0; k < int'(LAP_DEPTH); k++) laps_q[k] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            press_q <= sync2_q & ~sync3_q;

            if (do_start && !running_q) begin
                div_q <= '0;
            end else begin
                div_q <= tick_edge ? '0 : div_q + DW'(1);
            end

            if (do_clear) begin
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else if (running_q && tick_edge) begin
                count_q <= count_inc;
                if (wrap) overflow_q <= 1'b1;
            end

            if (do_clear || do_stop) begin
                running_q <= 1'b0;
            end else if (do_start) begin
                running_q <= 1'b1;
            end

            // Shift-in keeps the newest lap at index 0; the oldest falls off the end.
            if (do_clear) begin
                lap_count_q <= '0;
            end else if (do_lap && running_q) begin
                for (int k = int'(LAP_DEPTH) - 1; k > 0; k--) laps_q[k] <= laps_q[k-1];
                laps_q[0] <= count_q;
                if (lap_count_q != LCW'(LAP_DEPTH)) lap_count_q <= lap_count_q + LCW'(1);
            end
        end
    end

    always_comb begin
        mode_d = mode_q;
        idx_d  = idx_q;
        hold_d = hold_q;
        if (do_clear) begin
            mode_d = StLive;
        end else begin
            unique case (mode_q)
                StLive: begin
                    if (do_recall && (lap_count_q != '0)) begin
                        mode_d = StShowLap;
                        idx_d  = '0;
                        hold_d = HW'(LAP_HOLD);
                    end
                end
                StShowLap: begin
                    if (do_recall) begin
                        idx_d  = (32'(idx_q) + 32'd1 >= 32'(lap_count_q)) ? '0 : idx_q + LIW'(1);
                        hold_d = HW'(LAP_HOLD);
                    end else if (tick_edge) begin
                        hold_d = hold_q - HW'(1);
                        if (hold_q <= HW'(1)) mode_d = StLive;
                    end
                end
                default: mode_d = StLive;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q <= StLive;
            idx_q  <= '0;
            hold_q <= '0;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
            hold_q <= hold_d;
        end
    end

    assign disp      = (mode_q == StShowLap) ? laps_q[idx_q] : count_q;
    assign cur_digit = disp[{scan_idx_q, 2'b00} +: 4];

    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_idx_q <= '0;
            scan_cnt_q <= '0;
            seg_q      <= 8'hFF;
            dig_q      <= NUM_DIGITS'(1);
        end else begin
            seg_q <= {~((mode_q == StShowLap) && (scan_idx_q == '0)), ~hex7(cur_digit)};
            dig_q <= NUM_DIGITS'(1) << scan_idx_q;
            if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                scan_idx_q <= (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
            end else begin
                scan_cnt_q <= scan_cnt_q + SW'(1);
            end
        end
    end

    assign seg_n     = seg_q;
    assign dig_sel   = dig_q;
    assign running   = running_q;
    assign overflow  = overflow_q;
    assign lap_count = lap_count_q;

endmodule

// File: tb/tb_stopwatch_mux.sv
// Bench for stopwatch_mux: an integer-level reference model is compared with the DUT
// every cycle. Directed scenarios use hand-computed literal expectations, and a
// random phase follows them.
module tb_stopwatch_mux;

    localparam int ND = 4, TD = 4, SD = 2, LD = 2, LH = 3;
    localparam int MaxV = 10000;
    localparam logic [4:0] BtnClear = 5'b00001, BtnStop = 5'b00010, BtnStart = 5'b00100;
    localparam logic [4:0] BtnLap = 5'b01000, BtnRecall = 5'b10000;

    logic CLK = 1'b0, RST = 1'b1;
    logic b_clear = 0, b_start = 0, b_stop = 0, b_lap = 0, b_recall = 0;
    logic [7:0] seg_n;
    logic [ND-1:0] dig_sel;
    logic running, overflow;
    logic [1:0] lap_count;

    stopwatch_mux #(
        .NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .LAP_DEPTH(LD), .LAP_HOLD(LH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .btn_clear(b_clear), .btn_start(b_start), .btn_stop(b_stop),
        .btn_lap(b_lap), .btn_recall(b_recall),
        .seg_n(seg_n), .dig_sel(dig_sel), .running(running),
        .overflow(overflow), .lap_count(lap_count)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [6:0] hexpat(input logic [3:0] d);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[d];
    endfunction

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int seg2dig(input logic [6:0] s);
        for (int k = 0; k < 10; k++) if (~hexpat(4'(k)) == s) return k;
        return -1;
    endfunction

    // Reference model: integer count, button history, lap list with newest at index 0.
    logic [4:0] h1, h2, h3, h4;
    int m_count, m_div, m_lapn, m_idx, m_hold, m_sidx, m_scnt;
    bit m_run, m_ovf, m_show, m_valid = 0;
    int m_laps [LD];
    logic [7:0] m_seg;
    logic [ND-1:0] m_dig;

    always @(posedge CLK) begin
        automatic logic [4:0] act = h3 & ~h4;
        automatic bit tick = (m_div == TD - 1);
        automatic int c, dv, lapn, idx, hold, disp, d;
        automatic bit ov, run, show;
        if (RST) begin
            h1 <= 0; h2 <= 0; h3 <= 0; h4 <= 0;
            m_count <= 0; m_div <= 0; m_run <= 0; m_ovf <= 0; m_lapn <= 0;
            m_show <= 0; m_idx <= 0; m_hold <= 0; m_sidx <= 0; m_scnt <= 0;
            m_seg <= 8'hFF; m_dig <= 1; m_valid <= 1;
        end else begin
            disp = m_show ? m_laps[m_idx] : m_count;
            d = (disp / pow10(m_sidx)) % 10;
            m_seg <= {!(m_show && m_sidx == 0), ~hexpat(4'(d))};
            m_dig <= ND'(1) << m_sidx;
            if (m_scnt == SD - 1) begin
                m_scnt <= 0;
                m_sidx <= (m_sidx + 1) % ND;
            end else m_scnt <= m_scnt + 1;
            h1 <= {b_recall, b_lap, b_start, b_stop, b_clear};
            h2 <= h1; h3 <= h2; h4 <= h3;

            c = m_count; ov = m_ovf; run = m_run; dv = tick ? 0 : m_div + 1;
            lapn = m_lapn; show = m_show; idx = m_idx; hold = m_hold;
            if (m_run && tick) begin
                c = (m_count + 1) % MaxV;
                if (c == 0) ov = 1;
            end
            if (act[0]) begin
                c = 0; ov = 0; run = 0; lapn = 0; show = 0;
            end else if (act[1]) run = 0;
            else if (act[2]) begin
                if (!m_run) begin run = 1; dv = 0; end
            end else if (act[3]) begin
                if (m_run) begin
                    for (int k = LD - 1; k > 0; k--) m_laps[k] <= m_laps[k-1];
                    m_laps[0] <= m_count;
                    lapn = (m_lapn < LD) ? m_lapn + 1 : LD;
                end
            end else if (act[4]) begin
                if (!m_show && m_lapn > 0) begin
                    show = 1; idx = 0; hold = LH;
                end else if (m_show) begin
                    idx = (m_idx + 1) % m_lapn; hold = LH;
                end
            end
            if (!act[0] && !(act[4] && act[3:0] == 0) && m_show && tick) begin
                hold = m_hold - 1;
                if (hold == 0) show = 0;
            end
            m_count <= c; m_ovf <= ov; m_run <= run; m_div <= dv; m_lapn <= lapn;
            m_show <= show; m_idx <= idx; m_hold <= hold;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            check("seg_n", seg_n, m_seg);
            check("dig_sel", dig_sel, m_dig);
            check("running", running, m_run);
            check("overflow", overflow, m_ovf);
            check("lap_count", lap_count, m_lapn);
        end
    end

    task automatic set_btns(input logic [4:0] m);
        {b_recall, b_lap, b_start, b_stop, b_clear} = m;
    endtask

    task automatic wait_edge(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    // Button is high for exactly one sampling edge; edge_s returns that edge.
    task automatic press(input logic [4:0] m, output int edge_s);
        @(negedge CLK);
        set_btns(m);
        edge_s = cyc + 1;
        @(negedge CLK);
        set_btns(5'b0);
    endtask

    task automatic press_at(input logic [4:0] m, input int t);
        wait_edge(t - 1);
        check("press_schedule", cyc, t - 1);
        set_btns(m);
        @(negedge CLK);
        set_btns(5'b0);
    endtask

    task automatic read_val(output int v);
        int d, n;
        v = 0;
        for (int i = 0; i < ND; i++) begin
            n = 0;
            while (dig_sel !== ND'(1 << i) && n < 20) begin
                @(negedge CLK);
                n++;
            end
            d = (n >= 20) ? -1 : seg2dig(seg_n[6:0]);
            if (d < 0) begin
                v = -1;
                return;
            end
            v += d * pow10(i);
        end
    endtask

    task automatic check_dig0(input int lo, input int hi, input logic [7:0] exp,
                              input logic [7:0] mask, input string name);
        bit found = 0;
        wait_edge(lo);
        while (cyc <= hi && !found) begin
            if (dig_sel === ND'(1)) begin
                found = 1;
                check(name, seg_n & mask, exp);
            end else @(negedge CLK);
        end
        if (!found) check({name, "_window"}, 0, 1);
    endtask

    initial begin
        int x, s, a, v, hold_left;
        logic [4:0] mask;
        logic [7:0] exp1234 [4];
        exp1234[0] = 8'h99; exp1234[1] = 8'hB0; exp1234[2] = 8'hA4; exp1234[3] = 8'hF9;
        hold_left = 0;

        repeat (3) @(negedge CLK);
        check("reset_seg", seg_n, 8'hFF);
        check("reset_dig", dig_sel, 4'b0001);
        check("reset_run", running, 0);
        check("reset_ovf", overflow, 0);
        check("reset_laps", lap_count, 0);
        RST = 0;

        // Ten ticks after start; stop lands between tick 10 and tick 11.
        press(BtnStart, x);
        s = x + 3;
        wait_edge(s);
        check("run_after_start", running, 1);
        press_at(BtnStop, x + 42);
        wait_edge(x + 46);
        check("stopped", running, 0);
        read_val(v);
        check("count_10", v, 10);

        // 10000 ticks wraps 9999 to 0000 and sets overflow.
        press(BtnClear, x);
        press(BtnStart, x);
        press_at(BtnStop, x + 40002);
        wait_edge(x + 40006);
        check("ovf_set", overflow, 1);
        read_val(v);
        check("ovf_count", v, 0);
        press(BtnClear, x);
        wait_edge(x + 4);
        check("clear_ovf", overflow, 0);
        check("clear_run", running, 0);

        // Laps at 3, 5, 7 with depth 2, then recall newest/older/wrap.
        press(BtnClear, x);
        press(BtnStart, x);
        s = x + 3;
        press_at(BtnLap, s + 11);
        press_at(BtnLap, s + 19);
        press_at(BtnLap, s + 27);
        wait_edge(s + 31);
        check("lap_sat", lap_count, 2);
        a = s + 37;
        fork
            begin
                press_at(BtnRecall, a - 3);
                press_at(BtnRecall, a + 5);
                press_at(BtnRecall, a + 13);
            end
            begin
                check_dig0(a + 1, a + 8, 8'h78, 8'hFF, "recall_newest");
                check_dig0(a + 9, a + 16, 8'h12, 8'hFF, "recall_older");
                check_dig0(a + 17, a + 24, 8'h78, 8'hFF, "recall_wrap");
                check_dig0(a + 28, a + 40, 8'h80, 8'h80, "hold_expired_dp");
            end
        join

        // Coincident presses and lap while stopped.
        press(BtnClear, x);
        press(BtnStart | BtnStop, x);
        wait_edge(x + 4);
        check("stop_beats_start", running, 0);
        press(BtnStart, x);
        wait_edge(x + 4);
        check("start_again", running, 1);
        press(BtnClear | BtnLap, x);
        wait_edge(x + 4);
        check("clear_beats_lap", lap_count, 0);
        press(BtnLap, x);
        wait_edge(x + 4);
        check("lap_while_stopped", lap_count, 0);

        // Held buttons: one start action; recall with no laps stays live.
        @(negedge CLK);
        b_start = 1;
        repeat (50) @(negedge CLK);
        b_start = 0;
        check("held_start", running, 1);
        press(BtnClear, x);
        wait_edge(x + 4);
        b_recall = 1;
        repeat (30) begin
            @(negedge CLK);
            if (dig_sel === ND'(1)) check("recall_empty_dp", seg_n[7], 1);
        end
        b_recall = 0;

        // Count 1234 and scan order, then reset mid-scan.
        press(BtnClear, x);
        press(BtnStart, x);
        press_at(BtnStop, x + 4938);
        wait_edge(x + 4942);
        for (int i = 0; i < ND; i++) begin
            int n = 0;
            while (dig_sel !== ND'(1 << i) && n < 20) begin
                @(negedge CLK);
                n++;
            end
            check("scan_1234", seg_n, exp1234[i]);
        end
        begin
            int n = 0;
            while (dig_sel !== 4'b0100 && n < 20) begin
                @(negedge CLK);
                n++;
            end
        end
        RST = 1;
        @(negedge CLK);
        check("midscan_rst_seg", seg_n, 8'hFF);
        check("midscan_rst_dig", dig_sel, 4'b0001);
        RST = 0;

        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            if (hold_left == 0) begin
                mask = 0;
                mask[0] = ($urandom_range(0, 299) == 0);
                mask[1] = ($urandom_range(0, 39) == 0);
                mask[2] = ($urandom_range(0, 14) == 0);
                mask[3] = ($urandom_range(0, 9) == 0);
                mask[4] = ($urandom_range(0, 9) == 0);
                set_btns(mask);
                hold_left = $urandom_range(1, 4);
            end else hold_left--;
            RST = ($urandom_range(0, 1499) == 0);
        end
        @(negedge CLK);
        set_btns(5'b0);
        RST = 0;
        repeat (10) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
